// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution unit.
// Holds the opcode/operand/instruction encodings, FSM states and sizing constants.
package instr_register_pkg;

    localparam int NUM_REGS  = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;
    typedef logic        [5:0]  count_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // DIVIDE is the divider wait state; the name DIV is taken by the opcode.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DIVIDE = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } exec_state_t;

endpackage

// File: rtl/instr_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses DIV_ITERS cycles after load.
// quotient/remainder show the post-step values and are final in the cycle done is high.
module instr_div_seq
    import instr_register_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] div_q;
    count_t      iter_q;
    logic        running_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {1'b0, div_q};
        fits      = (shifted >= {1'b0, div_q});
        remainder = fits ? diff[31:0] : shifted[31:0];
        quotient  = {quo_q[30:0], fits};
        done      = running_q && (iter_q == count_t'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            iter_q    <= '0;
            running_q <= 1'b0;
        end else if (load) begin
            quo_q     <= dividend;
            rem_q     <= '0;
            div_q     <= divisor;
            iter_q    <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            quo_q  <= quotient;
            rem_q  <= remainder;
            iter_q <= iter_q + count_t'(1);
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Walks count entries from start_addr, executes each and writes the 64-bit result back.
// FETCH->res_valid is 2 cycles (34 for DIV/MOD); WRITE holds until res_ready, next FETCH follows.
module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     start_addr,
    input  count_t       count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output address_t     res_addr,
    output result_t      res_value,
    output logic         div_by_zero,
    output logic         illegal_op,
    output logic         busy,
    output logic         done
);

    exec_state_t  state;
    exec_state_t  next_state;
    address_t     ptr;
    count_t       remaining;
    instruction_t instr;

    logic        is_divop;
    logic        b_zero;
    logic        use_div;
    logic        illegal;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_load;
    logic        div_done;
    logic [31:0] quo;
    logic [31:0] rem;
    result_t     a64;
    result_t     b64;
    result_t     alu_result;
    result_t     q64;
    result_t     r64;
    result_t     div_fixed;

    instr_div_seq u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        a64      = result_t'(instr.op_a);
        b64      = result_t'(instr.op_b);
        is_divop = (instr.opc == DIV) || (instr.opc == MOD);
        b_zero   = (instr.op_b == '0);
        use_div  = is_divop && !b_zero;
        illegal  = instr.opc[3];
        a_neg    = instr.op_a[31];
        b_neg    = instr.op_b[31];
        mag_a    = a_neg ? (~instr.op_a + 32'd1) : instr.op_a;
        mag_b    = b_neg ? (~instr.op_b + 32'd1) : instr.op_b;
        // Magnitudes are zero-extended so -2^31 / -1 yields +2^31 without overflow.
        q64      = {32'd0, quo};
        r64      = {32'd0, rem};
        if (instr.opc == DIV) begin
            div_fixed = (a_neg ^ b_neg) ? -q64 : q64;
        end else begin
            div_fixed = a_neg ? -r64 : r64;
        end
        case (instr.opc)
            PASSA:   alu_result = a64;
            PASSB:   alu_result = b64;
            ADD:     alu_result = a64 + b64;
            SUB:     alu_result = a64 - b64;
            MULT:    alu_result = a64 * b64;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (count == '0) ? DONE : FETCH;
            FETCH:   next_state = EXEC;
            EXEC:    next_state = use_div ? DIVIDE : WRITE;
            DIVIDE:  if (div_done) next_state = WRITE;
            WRITE:   if (res_ready) next_state = (remaining == count_t'(1)) ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        done         = (state == DONE);
        res_valid    = (state == WRITE);
        div_load     = (state == EXEC) && use_div;
        read_pointer = ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            remaining   <= '0;
            instr       <= '0;
            res_addr    <= '0;
            res_value   <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= start_addr;
                        remaining <= count;
                    end
                end
                FETCH: instr <= instruction_word;
                EXEC: begin
                    res_addr    <= ptr;
                    div_by_zero <= is_divop && b_zero;
                    illegal_op  <= illegal;
                    if (!use_div) begin
                        res_value <= alu_result;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        res_value <= div_fixed;
                    end
                end
                WRITE: begin
                    if (res_ready) begin
                        ptr       <= ptr + address_t'(1);
                        remaining <= remaining - count_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized scoreboard bench for instr_exec_unit: driver pushes model results, monitor compares.
// Reference results use plain 64-bit integer arithmetic on the register contents.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    address_t     start_addr = '0;
    count_t       count = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready = 1'b0;
    address_t     res_addr;
    result_t      res_value;
    logic         div_by_zero;
    logic         illegal_op;
    logic         busy;
    logic         done;

    instr_exec_unit dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_addr         (res_addr),
        .res_value        (res_value),
        .div_by_zero      (div_by_zero),
        .illegal_op       (illegal_op),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    instruction_t regs [NUM_REGS];
    assign instruction_word = regs[read_pointer];

    typedef struct {
        address_t addr;
        result_t  val;
        bit       dbz;
        bit       ill;
        bit       last;
        int       lat;
    } exp_t;

    exp_t    sbq [$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      ready_mode = 2;
    int      valid_age = 0;
    int      launch = 0;
    int      exp_done = -1;
    bit      first = 1'b0;
    bit      hold_chk = 1'b0;
    result_t last_val = '0;
    exp_t    mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input instruction_t w, input address_t a, input bit last);
        exp_t   e;
        longint x;
        longint y;
        x      = longint'(w.op_a);
        y      = longint'(w.op_b);
        e.addr = a;
        e.val  = 0;
        e.dbz  = 1'b0;
        e.ill  = 1'b0;
        e.last = last;
        e.lat  = 2;
        case (w.opc)
            ZERO:  e.val = 0;
            PASSA: e.val = x;
            PASSB: e.val = y;
            ADD:   e.val = x + y;
            SUB:   e.val = x - y;
            MULT:  e.val = x * y;
            DIV: begin
                if (y == 0) e.dbz = 1'b1;
                else begin e.val = x / y; e.lat = 34; end
            end
            MOD: begin
                if (y == 0) e.dbz = 1'b1;
                else begin e.val = x % y; e.lat = 34; end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic operand_t rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'sd0;
            1:       return -32'sd1;
            2:       return 32'sd1;
            3:       return 32'sh8000_0000;
            4:       return 32'sh7fff_ffff;
            5:       return operand_t'($urandom_range(0, 40)) - 32'sd20;
            default: return operand_t'($urandom);
        endcase
    endfunction

    function automatic instruction_t rand_instr();
        instruction_t w;
        if ($urandom_range(0, 9) == 0) w.opc = opcode_t'(4'($urandom_range(8, 15)));
        else                           w.opc = opcode_t'(4'($urandom_range(0, 7)));
        w.op_a = rand_operand();
        w.op_b = rand_operand();
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready generator: 0 random, 1 low for the first 3 valid cycles of each result, 2 always high.
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) begin
            res_ready = ($urandom_range(0, 3) != 0);
        end else if (ready_mode == 1) begin
            if (res_valid) begin
                res_ready = (valid_age >= 3);
                valid_age++;
            end else begin
                res_ready = 1'b0;
                valid_age = 0;
            end
        end else begin
            res_ready = 1'b1;
        end
    end

    // Monitor: compares every presented result against the queue head, pops on handshake.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            sbq.delete();
            exp_done = -1;
            first    = 1'b0;
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("value_hold", res_value, last_val);
                hold_chk = 1'b0;
            end
            if (done || cyc == exp_done) check("done_pulse", done, cyc == exp_done);
            if (res_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res_valid: got res_valid=1 addr=%0d, required res_valid=0", res_addr);
                end else begin
                    mon_e = sbq[0];
                    if (first) begin
                        check("latency", cyc - launch, mon_e.lat);
                        first = 1'b0;
                    end
                    check("res_addr", res_addr, mon_e.addr);
                    check("res_value", res_value, mon_e.val);
                    check("div_by_zero", div_by_zero, mon_e.dbz);
                    check("illegal_op", illegal_op, mon_e.ill);
                    if (res_ready) begin
                        void'(sbq.pop_front());
                        last_val = mon_e.val;
                        hold_chk = 1'b1;
                        launch   = cyc + 1;
                        first    = !mon_e.last;
                        if (mon_e.last) exp_done = cyc + 1;
                    end
                end
            end
            if (start && !busy) begin
                launch = cyc + 1;
                first  = (count != '0);
                if (count == '0) exp_done = cyc + 1;
            end
        end
    end

    task automatic run_block(input address_t addr, input int cnt, input int mode, input bit poke);
        address_t a;
        ready_mode = mode;
        for (int i = 0; i < cnt; i++) begin
            a = addr + address_t'(i);
            sbq.push_back(model(regs[a], a, i == cnt - 1));
        end
        tick();
        start_addr = addr;
        count      = count_t'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_addr = address_t'($urandom);
        count      = count_t'($urandom_range(1, 32));
        if (poke) begin
            repeat (2) tick();
            if (busy) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        for (int k = 0; k < 3000 && (busy || sbq.size() != 0); k++) tick();
        if (busy || sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL block_timeout: busy=%0b pending=%0d, required busy=0 pending=0", busy, sbq.size());
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read_pointer"}, read_pointer, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_addr"}, res_addr, 0);
        check({tag, "_res_value"}, res_value, 0);
        check({tag, "_div_by_zero"}, div_by_zero, 0);
        check({tag, "_illegal_op"}, illegal_op, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = rand_instr();
        repeat (3) tick();
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        regs[0] = '{opc: ADD, op_a: 32'sd5, op_b: -32'sd7};
        run_block(5'd0, 1, 2, 1'b0);

        regs[3] = '{opc: MULT, op_a: 32'sh8000_0000, op_b: 32'sh8000_0000};
        regs[4] = '{opc: PASSB, op_a: 32'sd0, op_b: -32'sd1};
        run_block(5'd3, 2, 0, 1'b0);

        regs[10] = '{opc: DIV, op_a: -32'sd7, op_b: 32'sd2};
        regs[11] = '{opc: MOD, op_a: -32'sd7, op_b: 32'sd2};
        regs[12] = '{opc: DIV, op_a: 32'sh8000_0000, op_b: -32'sd1};
        run_block(5'd10, 3, 0, 1'b0);

        regs[20] = '{opc: DIV, op_a: 32'sd9, op_b: 32'sd0};
        regs[21] = '{opc: opcode_t'(4'hC), op_a: 32'sd3, op_b: 32'sd4};
        run_block(5'd20, 2, 2, 1'b0);

        run_block(5'd30, 4, 1, 1'b1);

        // Abort a block in the middle of a divide.
        regs[5] = '{opc: DIV, op_a: 32'sd100, op_b: 32'sd7};
        ready_mode = 2;
        tick();
        start_addr = 5'd5;
        count      = 6'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("busy_in_div", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (45) tick();

        run_block(5'd7, 0, 2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int r;
            int cnt;
            for (int i = 0; i < NUM_REGS; i++) regs[i] = rand_instr();
            r = $urandom_range(0, 9);
            if (r == 0)      cnt = 0;
            else if (r == 1) cnt = 32;
            else             cnt = $urandom_range(1, 6);
            run_block(address_t'($urandom), cnt, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
